cache_req_arbiter: RTL
======================

// Module: cache_req_arbiter
// PURPOSE
//  Two-requester round-robin arbiter in front of the direct-mapped cache's core request/response port.
//  Accepts one request at a time from port m0 or m1 and forwards it to the cache controller.
//  Routes the single cache response back to the owning port, then re-arbitrates.
//  One transaction in flight at most; no reordering.
// PARAMETERS
//  ADDR_WIDTH     32  request address width
//  DATA_WIDTH     32  data width; strobe width = DATA_WIDTH/8
//  TIMEOUT_CYCLES 256 WAIT_RESP watchdog limit (used only with CACHE_ARB_TIMEOUT_EN); >=2
// PORTS  (m<i> = m0 and m1, identical sets)
//  clk                  in  1            clock, rising edge
//  rst_n                in  1            asynchronous active-low reset
//  m<i>_req_valid       in  1            requester i has a request
//  m<i>_req_ready       out 1            request accepted this cycle
//  m<i>_req_we          in  1            1=write, 0=read
//  m<i>_req_addr        in  ADDR_WIDTH   byte address
//  m<i>_req_wdata       in  DATA_WIDTH   write data
//  m<i>_req_wstrb       in  DATA_WIDTH/8 byte strobes
//  m<i>_resp_valid      out 1            one-cycle response pulse
//  m<i>_resp_is_write   out 1            response belongs to a write
//  m<i>_resp_rdata      out DATA_WIDTH   read data (0 for writes)
//  m<i>_resp_resp       out 2            AXI-style code: 00 OKAY, 10 SLVERR
//  core_req_valid       out 1            request to cache controller
//  core_req_ready       in  1            cache controller accepts
//  core_req_we/addr/wdata/wstrb out as m<i>  latched request fields
//  core_resp_valid      in  1            cache response pulse (no backpressure)
//  core_resp_is_write   in  1            cache response type
//  core_resp_rdata      in  DATA_WIDTH   cache read data
//  core_resp_resp       in  2            cache response code
//  timeout_err          out 1            one-cycle pulse on watchdog abort (0 without macro)
// BEHAVIOUR
//  - Reset: state IDLE, last_grant=1 (m0 wins first), all outputs 0, holding regs 0.
//  - Reset mid-transaction: transaction dropped silently, no response issued.
//  - States: IDLE -> ISSUE -> WAIT_RESP -> IDLE.
//  - IDLE: m<i>_req_ready is combinational = (state==IDLE) && grant==i. Grant: if only one valid, that one;
//    if both, the port != last_grant. On accept: latch we/addr/wdata/wstrb and owner; last_grant<=owner; ->ISSUE.
//  - ISSUE: core_req_valid=1, core_req_* driven from holding regs, stable until core_req_ready=1; then ->WAIT_RESP.
//  - WAIT_RESP: on core_resp_valid, register is_write/rdata/resp into owner's m<i>_resp_* with m<i>_resp_valid=1
//    for exactly one cycle (next cycle); non-owner resp outputs stay 0; ->IDLE same edge.
//  - Latency: accept cycle N -> core_req_valid from N+1; core_resp_valid at cycle M -> m<i>_resp_valid at M+1.
//  - New request may be accepted in cycle M+1 (IDLE) concurrently with the response pulse.
//  - core_resp_valid outside WAIT_RESP is ignored (including the core_req_ready cycle).
//  - Requester must hold req fields stable while valid and not ready; valid dropped before ready is legal.
//  - m<i>_resp_* hold 0 when m<i>_resp_valid=0.
// CONFIGURATION
//  CACHE_ARB_TIMEOUT_EN defined: 8-bit-or-wider counter clears on entry to WAIT_RESP, increments each
//    WAIT_RESP cycle; if count reaches TIMEOUT_CYCLES-1 with no core_resp_valid: owner gets resp_valid=1,
//    resp=2'b10, rdata=0, is_write=latched we; timeout_err pulses 1 cycle; ->IDLE. Response on the
//    limit cycle wins over the timeout.
//  Not defined: no counter, WAIT_RESP waits indefinitely, timeout_err tied 0.
// TESTING
//  1 Reset: rst_n=0 async mid-cycle -> all outputs 0 immediately; after release m0/m1_req_ready=0 until valid.
//  2 m0 read addr 0x40 alone; cache ready at once, resp rdata=0xDEADBEEF 3 cycles later ->
//    core_req_valid 1 cycle after accept, m0_resp_valid 1 cycle after core_resp_valid, rdata=0xDEADBEEF, m1 idle.
//  3 m0 and m1 valid every cycle, 4 transactions -> grant order m0,m1,m0,m1; no port granted twice in a row.
//  4 m1 write addr 0x80 wdata 0x12345678 wstrb 0xF, core_req_ready low 5 cycles -> core_req_* stable all 5,
//    m1_resp_is_write=1, m1_resp_resp=00.
//  5 Spurious core_resp_valid in IDLE and ISSUE -> no m<i>_resp_valid, state unchanged.
//  6 With CACHE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no response -> m0_resp_resp=2'b10 and timeout_err=1
//    16 cycles after WAIT_RESP entry; without macro still waiting after 1000 cycles.

Source files
------------

// File: rtl/cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_req_arbiter
// Purpose  : Two-requester round-robin arbiter in front of the direct-mapped
//            cache's core request/response port. One transaction is in flight
//            at a time. Each response is routed back to the port that issued
//            the request, and then the arbiter picks the next request.
// Ports    : clk, rst_n                  - clock (rising edge), async active-low reset
//            m0_req_* / m1_req_*         - requester request channels (valid/ready)
//            m0_resp_* / m1_resp_*       - one-cycle response pulses to requesters
//            core_req_*                  - request to the cache controller (valid/ready)
//            core_resp_*                 - cache response pulse (no backpressure)
//            timeout_err                 - one-cycle pulse on watchdog abort
// Options  : CACHE_ARB_TIMEOUT_EN        - enables the WAIT_RESP watchdog
//                                          (TIMEOUT_CYCLES); undefined = no watchdog
// Revision : 1.0 - initial release
// ============================================================================
module cache_req_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    m0_req_valid,
    output logic                    m0_req_ready,
    input  logic                    m0_req_we,
    input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
    input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_req_wstrb,
    output logic                    m0_resp_valid,
    output logic                    m0_resp_is_write,
    output logic [DATA_WIDTH-1:0]   m0_resp_rdata,
    output logic [1:0]              m0_resp_resp,

    input  logic                    m1_req_valid,
    output logic                    m1_req_ready,
    input  logic                    m1_req_we,
    input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
    input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_req_wstrb,
    output logic                    m1_resp_valid,
    output logic                    m1_resp_is_write,
    output logic [DATA_WIDTH-1:0]   m1_resp_rdata,
    output logic [1:0]              m1_resp_resp,

    output logic                    core_req_valid,
    input  logic                    core_req_ready,
    output logic                    core_req_we,
    output logic [ADDR_WIDTH-1:0]   core_req_addr,
    output logic [DATA_WIDTH-1:0]   core_req_wdata,
    output logic [DATA_WIDTH/8-1:0] core_req_wstrb,
    input  logic                    core_resp_valid,
    input  logic                    core_resp_is_write,
    input  logic [DATA_WIDTH-1:0]   core_resp_rdata,
    input  logic [1:0]              core_resp_resp,

    output logic                    timeout_err
);

    localparam int         c_STRB_W   = DATA_WIDTH / 8;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // The watchdog needs at least one counted cycle before it can fire.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout_cfg
        $error("cache_req_arbiter: TIMEOUT_CYCLES must be >= 2");
    end

    logic [1:0]            r_state;
    logic                  r_last_grant;
    logic                  r_owner;
    logic                  r_req_we;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [DATA_WIDTH-1:0] r_req_wdata;
    logic [c_STRB_W-1:0]   r_req_wstrb;

    logic                  r_m0_resp_valid;
    logic                  r_m0_resp_is_write;
    logic [DATA_WIDTH-1:0] r_m0_resp_rdata;
    logic [1:0]            r_m0_resp_resp;
    logic                  r_m1_resp_valid;
    logic                  r_m1_resp_is_write;
    logic [DATA_WIDTH-1:0] r_m1_resp_rdata;
    logic [1:0]            r_m1_resp_resp;
    logic                  r_timeout_err;

    logic                  w_idle;
    logic                  w_grant;
    logic                  w_accept;
    logic                  w_timeout;
    logic                  w_resp_fire;
    logic                  w_resp_is_write;
    logic [DATA_WIDTH-1:0] w_resp_rdata;
    logic [1:0]            w_resp_code;

    // ------------------------------------------------------------------
    // Grant selection: a lone requester always wins; on contention the
    // port that was not served last goes next.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = 1'b0;
        if (m0_req_valid && !m1_req_valid) begin
            w_grant = 1'b0;
        end else if (m1_req_valid && !m0_req_valid) begin
            w_grant = 1'b1;
        end else if (m0_req_valid && m1_req_valid) begin
            w_grant = ~r_last_grant;
        end
    end

    assign w_idle       = (r_state == c_ST_IDLE);
    assign m0_req_ready = w_idle && m0_req_valid && (w_grant == 1'b0);
    assign m1_req_ready = w_idle && m1_req_valid && (w_grant == 1'b1);
    assign w_accept     = m0_req_ready || m1_req_ready;

    // ------------------------------------------------------------------
    // Optional WAIT_RESP watchdog
    // ------------------------------------------------------------------
`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if ((r_state == c_ST_ISSUE) && core_req_ready) begin
            r_wait_cnt <= '0;
        end else if (r_state == c_ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
        end
    end

    // A real response arriving on the limit cycle takes priority.
    assign w_timeout = (r_state == c_ST_WAIT) && !core_resp_valid &&
                       (r_wait_cnt == c_CNT_LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Response source: cache response, or a synthesized SLVERR on timeout
    // ------------------------------------------------------------------
    assign w_resp_fire     = (r_state == c_ST_WAIT) && (core_resp_valid || w_timeout);
    assign w_resp_is_write = core_resp_valid ? core_resp_is_write : r_req_we;
    assign w_resp_rdata    = core_resp_valid ? core_resp_rdata    : '0;
    assign w_resp_code     = core_resp_valid ? core_resp_resp     : c_RESP_SLVERR;

    // ------------------------------------------------------------------
    // Control FSM and request holding registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_req_we     <= 1'b0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_req_wstrb  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_req_we     <= w_grant ? m1_req_we    : m0_req_we;
                        r_req_addr   <= w_grant ? m1_req_addr  : m0_req_addr;
                        r_req_wdata  <= w_grant ? m1_req_wdata : m0_req_wdata;
                        r_req_wstrb  <= w_grant ? m1_req_wstrb : m0_req_wstrb;
                        r_state      <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    if (core_req_ready) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (w_resp_fire) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered response outputs: only the owner's set is loaded, and
    // everything returns to zero the cycle after the pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m0_resp_valid    <= 1'b0;
            r_m0_resp_is_write <= 1'b0;
            r_m0_resp_rdata    <= '0;
            r_m0_resp_resp     <= 2'b00;
            r_m1_resp_valid    <= 1'b0;
            r_m1_resp_is_write <= 1'b0;
            r_m1_resp_rdata    <= '0;
            r_m1_resp_resp     <= 2'b00;
            r_timeout_err      <= 1'b0;
        end else begin
            r_m0_resp_valid    <= w_resp_fire && !r_owner;
            r_m0_resp_is_write <= (w_resp_fire && !r_owner) ? w_resp_is_write : 1'b0;
            r_m0_resp_rdata    <= (w_resp_fire && !r_owner) ? w_resp_rdata    : '0;
            r_m0_resp_resp     <= (w_resp_fire && !r_owner) ? w_resp_code     : 2'b00;
            r_m1_resp_valid    <= w_resp_fire && r_owner;
            r_m1_resp_is_write <= (w_resp_fire && r_owner) ? w_resp_is_write : 1'b0;
            r_m1_resp_rdata    <= (w_resp_fire && r_owner) ? w_resp_rdata    : '0;
            r_m1_resp_resp     <= (w_resp_fire && r_owner) ? w_resp_code     : 2'b00;
            r_timeout_err      <= w_timeout;
        end
    end

    assign core_req_valid   = (r_state == c_ST_ISSUE);
    assign core_req_we      = r_req_we;
    assign core_req_addr    = r_req_addr;
    assign core_req_wdata   = r_req_wdata;
    assign core_req_wstrb   = r_req_wstrb;

    assign m0_resp_valid    = r_m0_resp_valid;
    assign m0_resp_is_write = r_m0_resp_is_write;
    assign m0_resp_rdata    = r_m0_resp_rdata;
    assign m0_resp_resp     = r_m0_resp_resp;
    assign m1_resp_valid    = r_m1_resp_valid;
    assign m1_resp_is_write = r_m1_resp_is_write;
    assign m1_resp_rdata    = r_m1_resp_rdata;
    assign m1_resp_resp     = r_m1_resp_resp;
    assign timeout_err      = r_timeout_err;

endmodule
`default_nettype wire
